// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Arbitrates an instruction-fetch port and a data port onto one shared
//   memory port. One access is in flight at a time (IDLE -> BUSY -> DONE).
//   Conflicting requests alternate round-robin. A BUSY access that sees no
//   mem_ready for TIMEOUT cycles completes with err=1.
// Ports:
//   clk, reset                     clock, async active-high reset
//   if_req/if_addr                 fetch request (read only)
//   if_valid/if_rdata              fetch completion pulse and data
//   d_req/d_we/d_addr/d_wdata      data-port request
//   d_valid/d_rdata                data completion pulse and read data
//   err                            last completion was a timeout
//   mem_req/mem_we/mem_addr/mem_wdata, mem_ready/mem_rdata  shared memory
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_valid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_valid,
  output logic [DW-1:0] d_rdata,
  output logic          err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  // Counter value of the final allowed BUSY cycle.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic            last_data_q, last_data_d;   // 1: data port was granted last
  logic            gnt_data_q, gnt_data_d;     // 1: current access is data port
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            if_valid_q, if_valid_d;
  logic            d_valid_q, d_valid_d;
  logic [DW-1:0]   if_rdata_q, if_rdata_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic            err_q, err_d;
  logic            pick_data;
  logic [DW-1:0]   rdata_cap;

  always_comb begin
    state_d     = state_q;
    last_data_d = last_data_q;
    gnt_data_d  = gnt_data_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    err_d       = err_q;

    // Data wins when it is alone, or on a conflict if fetch went last.
    pick_data = d_req & (~if_req | ~last_data_q);
    // Writes and timeouts return zero data.
    rdata_cap = (mem_ready && !we_q) ? mem_rdata : '0;

    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          gnt_data_d  = pick_data;
          last_data_d = pick_data;
          we_d        = pick_data & d_we;
          addr_d      = pick_data ? d_addr : if_addr;
          wdata_d     = pick_data ? d_wdata : '0;
          cnt_d       = '0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        // mem_ready takes priority over an expiring timeout.
        if (mem_ready || cnt_q == CNT_LAST) begin
          err_d = ~mem_ready;
          if (gnt_data_q) begin
            d_rdata_d = rdata_cap;
            d_valid_d = 1'b1;
          end else begin
            if_rdata_d = rdata_cap;
            if_valid_d = 1'b1;
          end
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      last_data_q <= 1'b1;
      gnt_data_q  <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_data_q <= last_data_d;
      gnt_data_q  <= gnt_data_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      err_q       <= err_d;
    end
  end

  assign mem_req   = (state_q == BUSY);
  assign mem_we    = mem_req & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_valid  = if_valid_q;
  assign d_valid   = d_valid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_valid;
  logic [DW-1:0] if_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_valid;
  logic [DW-1:0] d_rdata;
  logic          err;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  int n_checks = 0;
  int n_pass = 0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_valid(d_valid), .d_rdata(d_rdata), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Transaction-level reference: an access occupies some number of BUSY
  // cycles (age), then one completion cycle, then the arbiter looks again.
  bit          m_busy = 0;
  bit          m_done = 0;
  int          m_age = 0;
  bit          m_gd = 0;
  bit          m_last_d = 1;
  bit          m_we = 0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic        e_if_valid = 0, e_d_valid = 0, e_err = 0;
  logic [31:0] e_if_rdata = '0, e_d_rdata = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 0; m_done = 0; m_age = 0; m_last_d = 1; m_we = 0;
      m_addr = '0; m_wdata = '0;
      e_if_valid = 0; e_d_valid = 0; e_err = 0; e_if_rdata = '0; e_d_rdata = '0;
    end else begin
      e_if_valid = 0;
      e_d_valid = 0;
      if (m_busy) begin
        m_age = m_age + 1;
        if (mem_ready || m_age >= TIMEOUT) begin
          logic [31:0] rd;
          rd = (mem_ready && !m_we) ? mem_rdata : 32'h0;
          e_err = !mem_ready;
          if (m_gd) begin e_d_rdata = rd; e_d_valid = 1; end
          else begin e_if_rdata = rd; e_if_valid = 1; end
          m_busy = 0;
          m_done = 1;
        end
      end else if (m_done) begin
        m_done = 0;
      end else if (if_req || d_req) begin
        if (if_req && d_req) m_gd = !m_last_d;
        else m_gd = d_req;
        m_last_d = m_gd;
        m_we = m_gd && d_we;
        m_addr = m_gd ? d_addr : if_addr;
        m_wdata = d_wdata;
        m_age = 0;
        m_busy = 1;
      end
    end
  end

  always @(negedge clk) begin
    chk1("mem_req", mem_req, m_busy);
    if (m_busy) begin
      chk1("mem_we", mem_we, m_we);
      chk32("mem_addr", mem_addr, m_addr);
      if (m_we) chk32("mem_wdata", mem_wdata, m_wdata);
    end
    chk1("if_valid", if_valid, e_if_valid);
    chk1("d_valid", d_valid, e_d_valid);
    chk1("err", err, e_err);
    chk32("if_rdata", if_rdata, e_if_rdata);
    chk32("d_rdata", d_rdata, e_d_rdata);
    chk1("valid_excl", if_valid & d_valid, 1'b0);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit order [4];
    int ng;
    int cnt;

    // Reset state
    #2 reset = 1;
    cyc(); cyc();
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk32("rst_mem_addr", mem_addr, 32'h0);
    chk32("rst_mem_wdata", mem_wdata, 32'h0);
    chk32("rst_if_rdata", if_rdata, 32'h0);
    chk1("rst_err", err, 1'b0);
    reset = 0;
    cyc();

    // Single fetch, minimum latency
    if_req = 1; if_addr = 32'h100; mem_ready = 1; mem_rdata = 32'hDEADBEEF;
    cyc();
    chk1("sf_mem_req", mem_req, 1'b1);
    chk32("sf_mem_addr", mem_addr, 32'h100);
    chk1("sf_mem_we", mem_we, 1'b0);
    cyc();
    chk1("sf_if_valid", if_valid, 1'b1);
    chk32("sf_if_rdata", if_rdata, 32'hDEADBEEF);
    chk1("sf_err", err, 1'b0);
    chk1("sf_d_valid", d_valid, 1'b0);
    if_req = 0; mem_ready = 0;
    cyc(); cyc();

    // Conflict right after reset: fetch, data, fetch, data
    reset = 1;
    cyc();
    reset = 0;
    if_req = 1; if_addr = 32'h200; d_req = 1; d_we = 0; d_addr = 32'h204;
    mem_ready = 1; mem_rdata = 32'hCAFE0001;
    ng = 0;
    for (int c = 0; c < 20 && ng < 4; c++) begin
      cyc();
      chk1("cf_two_valids", if_valid & d_valid, 1'b0);
      if (if_valid) begin order[ng] = 0; ng++; end
      else if (d_valid) begin order[ng] = 1; ng++; end
    end
    if_req = 0; d_req = 0; mem_ready = 0;
    chk32("cf_grants", ng, 32'd4);
    chk1("cf_gnt0", order[0], 1'b0);
    chk1("cf_gnt1", order[1], 1'b1);
    chk1("cf_gnt2", order[2], 1'b0);
    chk1("cf_gnt3", order[3], 1'b1);
    cyc(); cyc();

    // Timeout: no mem_ready ever
    d_req = 1; d_we = 0; d_addr = 32'h40; mem_ready = 0;
    cyc();
    cnt = 0;
    while (mem_req && cnt < 40) begin
      cnt++;
      cyc();
    end
    chk32("to_busy_cycles", cnt, 32'd15);
    chk1("to_d_valid", d_valid, 1'b1);
    chk1("to_err", err, 1'b1);
    chk32("to_d_rdata", d_rdata, 32'h0);
    d_req = 0;
    cyc(); cyc();

    // mem_ready in the final allowed BUSY cycle wins over the timeout
    d_req = 1; d_addr = 32'h44; mem_ready = 0; mem_rdata = 32'hA5A5A5A5;
    for (int k = 1; k <= 15; k++) begin
      cyc();
      if (k == 15) mem_ready = 1;
    end
    cyc();
    chk1("tb15_d_valid", d_valid, 1'b1);
    chk1("tb15_err", err, 1'b0);
    chk32("tb15_d_rdata", d_rdata, 32'hA5A5A5A5);
    d_req = 0; mem_ready = 0;
    cyc(); cyc();

    // Data write with three wait cycles
    d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'h55; mem_ready = 0;
    mem_rdata = 32'hFFFF0000;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk1("wr_mem_req", mem_req, 1'b1);
      chk1("wr_mem_we", mem_we, 1'b1);
      chk32("wr_mem_addr", mem_addr, 32'h20);
      chk32("wr_mem_wdata", mem_wdata, 32'h55);
      if (i == 3) mem_ready = 1;
    end
    cyc();
    chk1("wr_mem_req_off", mem_req, 1'b0);
    chk1("wr_d_valid", d_valid, 1'b1);
    chk32("wr_d_rdata", d_rdata, 32'h0);
    chk1("wr_err", err, 1'b0);
    d_req = 0; d_we = 0; mem_ready = 0;
    cyc(); cyc();

    // Reset in the middle of an access
    if_req = 1; if_addr = 32'h300; mem_ready = 0;
    cyc(); cyc();
    reset = 1;
    #1;
    chk1("mr_mem_req", mem_req, 1'b0);
    cyc();
    chk1("mr_if_valid", if_valid, 1'b0);
    chk1("mr_d_valid", d_valid, 1'b0);
    reset = 0; mem_ready = 1; mem_rdata = 32'h12345678;
    cyc();
    chk1("mr_regrant", mem_req, 1'b1);
    chk32("mr_addr", mem_addr, 32'h300);
    cyc();
    chk1("mr_if_valid2", if_valid, 1'b1);
    chk32("mr_if_rdata", if_rdata, 32'h12345678);
    if_req = 0; mem_ready = 0;
    cyc(); cyc();

    // Randomized traffic, requesters obey the hold-until-valid rule
    for (int n = 0; n < 3000; n++) begin
      cyc();
      if (reset) reset = 0;
      else if ($urandom_range(799) == 0) reset = 1;
      mem_ready = ($urandom_range(3) == 0);
      mem_rdata = $urandom;
      if (if_valid) begin
        if_req = $urandom_range(1) == 1;
        if_addr = $urandom;
      end else if (!if_req && $urandom_range(2) == 0) begin
        if_req = 1;
        if_addr = $urandom;
      end
      if (d_valid) begin
        d_req = $urandom_range(1) == 1;
        d_we = $urandom_range(1) == 1;
        d_addr = $urandom;
        d_wdata = $urandom;
      end else if (!d_req && $urandom_range(2) == 0) begin
        d_req = 1;
        d_we = $urandom_range(1) == 1;
        d_addr = $urandom;
        d_wdata = $urandom;
      end
    end
    reset = 0; if_req = 0; d_req = 0; mem_ready = 1;
    repeat (20) cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-002 Parameters (name, default, meaning) SHALL be:
  AW, 32, address width
  DW, 32, data width
  TIMEOUT, 15, maximum BUSY cycles to wait for mem_ready (legal range 1..255)
REQ-003 Ports (name, direction, width, meaning) SHALL be:
  clk  in  1  clock, rising edge
  reset  in  1  async active-high reset
  if_req  in  1  instruction-fetch read request
  if_addr  in  AW  fetch address
  if_valid  out  1  one-cycle fetch completion pulse
  if_rdata  out  DW  fetch data, valid while if_valid=1
  d_req  in  1  data-port request
  d_we  in  1  data-port write enable
  d_addr  in  AW  data address
  d_wdata  in  DW  data write data
  d_valid  out  1  one-cycle data completion pulse
  d_rdata  out  DW  data read data, valid while d_valid=1
  err  out  1  completion was a timeout, qualifies if_valid/d_valid
  mem_req  out  1  shared memory request
  mem_we  out  1  shared memory write enable
  mem_addr  out  AW  shared memory address
  mem_wdata  out  DW  shared memory write data
  mem_ready  in  1  memory accepts or completes the access this cycle
  mem_rdata  in  DW  memory read data, valid with mem_ready

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-005 IDLE behaviour:
  - If no request is pending, the FSM SHALL stay in IDLE.
  - Otherwise it SHALL grant one requester, register its addr/we/wdata, and go to BUSY.
  - Fetch grants SHALL force we=0.
REQ-006 Arbitration:
  - A single pending request SHALL be granted.
  - If if_req and d_req are both 1, the port not granted last SHALL win (round-robin).
  - last_grant SHALL update on every grant.
REQ-007 BUSY behaviour:
  - mem_req SHALL be 1, with mem_we/mem_addr/mem_wdata driven from the registered values and held stable.
  - On mem_ready=1, the FSM SHALL capture mem_rdata (zero for writes) into the granted port's rdata register, set err=0, and go to DONE.
REQ-008 Timeout:
  - A BUSY cycle counter SHALL clear on entry to BUSY.
  - If the counter reaches TIMEOUT with mem_ready still 0, the FSM SHALL go to DONE with err=1 and the granted rdata set to 0.
  - mem_ready arriving in the same cycle as the timeout SHALL win (err=0).
REQ-009 DONE behaviour: the granted port's valid SHALL be 1 for exactly this cycle, mem_req SHALL be 0, and the next state SHALL be IDLE.
REQ-010 Request rule: a requester SHALL hold req, addr and wdata stable until its valid pulse. Req still high in the cycle after DONE SHALL be treated as a new request, which permits back-to-back accesses.
REQ-011 Minimum latency: req sampled in IDLE at cycle N, mem_req at N+1, mem_ready at N+1, valid at N+2; the next grant is sampled at N+3.
REQ-012 mem_req SHALL never be asserted outside BUSY, and both valid outputs SHALL never be 1 together.
REQ-013 Requests that arrive while in BUSY or DONE SHALL be ignored until IDLE and SHALL NOT be lost if still held.
REQ-014 if_rdata, d_rdata and err SHALL hold their last value between pulses.

Reset
REQ-015 Asserting reset SHALL immediately force:
  - state to IDLE
  - mem_req, mem_we, if_valid, d_valid and err to 0
  - mem_addr, mem_wdata, if_rdata, d_rdata and the counter to 0
  - last_grant to data, so fetch wins the first conflict
REQ-016 Reset mid-BUSY SHALL abort the access with no valid pulse. The first grant SHALL occur no earlier than the first rising edge after reset deasserts.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
  - Single fetch: if_req=1, if_addr=0x100, mem_ready=1 at N+1 with mem_rdata=0xDEADBEEF -> mem_addr=0x100 and mem_we=0 at N+1; if_valid=1, if_rdata=0xDEADBEEF, err=0 at N+2.
  - Conflict after reset: if_req=d_req=1 held -> grants in order fetch, data, fetch, data; never two valids together.
  - Data write with wait: d_we=1, d_addr=0x20, d_wdata=0x55, mem_ready delayed 3 cycles -> mem_req held 4 cycles with address and data stable; d_valid=1, d_rdata=0, err=0.
  - Timeout: d_req=1, mem_ready=0 forever -> mem_req deasserts after 15 BUSY cycles; d_valid=1, err=1, d_rdata=0; mem_ready at exactly cycle 15 -> err=0.
  - Mid-access reset: assert reset during BUSY -> mem_req=0 immediately, no valid pulse; after release, a held if_req is granted normally.
